// File: rtl/key_debounce.sv
// key_debounce: per-key two-flop synchroniser, shared sample prescaler and
// saturating integrator with hysteresis. Produces clean key levels plus
// one-cycle press/release strobes for the downstream priority encoder.
module key_debounce #(
  parameter int NUM_KEYS = 12,
  parameter int TICK_DIV = 500,
  parameter int CNT_MAX  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_db,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic                any_key
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [IW-1:0] INTEG_MAX  = IW'(CNT_MAX);
  localparam logic [IW-1:0] INTEG_ONE  = IW'(1);
  localparam logic [IW-1:0] INTEG_ZERO = '0;

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [PW-1:0]       presc_q;
  logic [PW-1:0]       presc_d;
  logic                tick;
  logic [IW-1:0]       integ_q [NUM_KEYS];
  logic [IW-1:0]       integ_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] set_d;
  logic [NUM_KEYS-1:0] clr_d;
  logic [NUM_KEYS-1:0] keys_db_q;
  logic [NUM_KEYS-1:0] keys_db_d;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] release_q;
  logic                any_key_q;

  // One tick per TICK_DIV cycles, on the last count before the wrap.
  assign tick = (presc_q == PRESC_LAST);

  // Prescaler next value: wrap to zero on the tick cycle.
  always_comb begin
    presc_d = presc_q + PRESC_ONE;
    if (tick) begin
      presc_d = '0;
    end
  end

  // Per-key integrator step and hysteresis decisions. The step is computed
  // every cycle but only committed (and only acted upon) on a tick.
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      assign integ_d[gi] = sync2_q[gi]
                         ? ((integ_q[gi] == INTEG_MAX)  ? integ_q[gi] : integ_q[gi] + INTEG_ONE)
                         : ((integ_q[gi] == INTEG_ZERO) ? integ_q[gi] : integ_q[gi] - INTEG_ONE);
      assign set_d[gi] = tick && (integ_d[gi] == INTEG_MAX)  && !keys_db_q[gi];
      assign clr_d[gi] = tick && (integ_d[gi] == INTEG_ZERO) &&  keys_db_q[gi];
    end
  endgenerate

  // Debounced level: set on reaching full scale, clear on reaching empty.
  always_comb begin
    keys_db_d = (keys_db_q | set_d) & ~clr_d;
  end

  // Two-flop synchroniser on the raw asynchronous pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
    end
  end

  // Shared sample prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Saturating integrators, advanced only on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        integ_q[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        integ_q[i] <= integ_d[i];
      end
    end
  end

  // Registered outputs; strobes and any_key change on the same edge as the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_db_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_key_q <= 1'b0;
    end else begin
      keys_db_q <= keys_db_d;
      press_q   <= set_d;
      release_q <= clr_d;
      any_key_q <= |keys_db_d;
    end
  end

  assign keys_db       = keys_db_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign any_key       = any_key_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: a fast instance (TICK_DIV=4, CNT_MAX=3)
// for most scenarios and a default-parameter instance for long latency.
module tb_key_debounce;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] keys_raw;
  logic [11:0] keys_db;
  logic [11:0] press_pulse;
  logic [11:0] release_pulse;
  logic        any_key;

  logic        rst2;
  logic [11:0] keys2;
  logic [11:0] keys_db2;
  logic [11:0] press2;
  logic [11:0] release2;
  logic        any_key2;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int unsigned edge_n = 0;

  typedef struct {
    logic [11:0] raw;
    logic [11:0] db;
    logic [11:0] pr;
    logic [11:0] rl;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  key_debounce #(.NUM_KEYS(12), .TICK_DIV(4), .CNT_MAX(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .keys_raw      (keys_raw),
    .keys_db       (keys_db),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .any_key       (any_key)
  );

  key_debounce #(.NUM_KEYS(12)) dut_def (
    .clk           (clk),
    .rst           (rst2),
    .keys_raw      (keys2),
    .keys_db       (keys_db2),
    .press_pulse   (press2),
    .release_pulse (release2),
    .any_key       (any_key2)
  );

  // Edge count since reset release, used only to align stimulus phase.
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %s: got %0h ok", name, act);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total_cnt++;
    if (act >= lo && act <= hi) begin
      pass_cnt++;
      $display("check %s: got %0d ok", name, act);
    end else begin
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait until keys_db differs from its value at call time; count any
  // strobe seen before the change.
  task automatic wait_db_change(input int limit, output int n, output int early);
    logic [11:0] prev;
    prev  = keys_db;
    early = 0;
    n     = limit + 1;
    for (int c = 1; c <= limit; c++) begin
      step();
      if (keys_db !== prev) begin
        n = c;
        break;
      end
      if ((press_pulse | release_pulse) != 12'h000) early++;
    end
  endtask

  initial begin
    int n;
    int early;
    int cnt_a;
    int cnt_b;

    tbl[0] = '{raw: 12'h000, db: 12'h000, pr: 12'h000, rl: 12'h800};
    tbl[1] = '{raw: 12'hA5A, db: 12'hA5A, pr: 12'hA5A, rl: 12'h000};
    tbl[2] = '{raw: 12'h5A5, db: 12'h5A5, pr: 12'h5A5, rl: 12'hA5A};
    tbl[3] = '{raw: 12'hFFF, db: 12'hFFF, pr: 12'hA5A, rl: 12'h000};
    tbl[4] = '{raw: 12'h000, db: 12'h000, pr: 12'h000, rl: 12'hFFF};
    tbl[5] = '{raw: 12'h001, db: 12'h001, pr: 12'h001, rl: 12'h000};

    rst      = 1'b1;
    keys_raw = 12'hFFF;
    rst2     = 1'b1;
    keys2    = 12'h000;

    // Reset values during and one cycle after reset.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outputs", {keys_db, press_pulse, release_pulse, any_key}, 64'h0);
    end
    rst = 1'b0;
    step();
    chk("post_reset_outputs", {keys_db, press_pulse, release_pulse, any_key}, 64'h0);
    keys_raw = 12'h000;
    repeat (8) step();

    // Single key press and release.
    keys_raw = 12'h001;
    wait_db_change(30, n, early);
    chk_range("press_latency", n, 11, 14);
    chk("press_db", keys_db, 12'h001);
    chk("press_pulse", press_pulse, 12'h001);
    chk("press_no_release", release_pulse, 12'h000);
    chk("press_any_key", any_key, 1'b1);
    chk("press_no_early_strobe", early, 0);
    step();
    chk("press_pulse_one_cycle", press_pulse, 12'h000);
    keys_raw = 12'h000;
    wait_db_change(30, n, early);
    chk_range("release_latency", n, 11, 14);
    chk("release_db", keys_db, 12'h000);
    chk("release_pulse", release_pulse, 12'h001);
    chk("release_no_press", press_pulse, 12'h000);
    chk("release_any_key", any_key, 1'b0);
    step();
    chk("release_pulse_one_cycle", release_pulse, 12'h000);

    // Glitch rejection on key 5: 3 high cycles out of every 12.
    cnt_a = 0;
    cnt_b = 0;
    for (int g = 0; g < 10; g++) begin
      keys_raw[5] = 1'b1;
      for (int c = 0; c < 12; c++) begin
        if (c == 3) keys_raw[5] = 1'b0;
        step();
        if (press_pulse != 12'h000) cnt_a++;
        if (keys_db != 12'h000) cnt_b++;
      end
    end
    repeat (12) begin
      step();
      if (press_pulse != 12'h000) cnt_a++;
      if (keys_db != 12'h000) cnt_b++;
    end
    chk("glitch_press_count", cnt_a, 0);
    chk("glitch_db_high_cycles", cnt_b, 0);

    // Chatter on key 11, aligned so each 5-cycle half-period moves the
    // integrator by a bounded amount that never reaches full scale.
    if (edge_n % 2 != 0) step();
    cnt_a = 0;
    for (int k = 0; k < 8; k++) begin
      keys_raw[11] = (k % 2 == 0);
      repeat (5) begin
        step();
        if (press_pulse != 12'h000) cnt_a++;
      end
    end
    chk("chatter_press_count", cnt_a, 0);
    keys_raw[11] = 1'b1;
    wait_db_change(30, n, early);
    chk_range("chatter_settle_latency", n, 1, 14);
    chk("chatter_settle_db", keys_db, 12'h800);
    chk("chatter_settle_press", press_pulse, 12'h800);
    step();
    chk("chatter_press_one_cycle", press_pulse, 12'h000);

    // Simultaneous multi-key events.
    for (int i = 0; i < 6; i++) begin
      keys_raw = tbl[i].raw;
      wait_db_change(30, n, early);
      chk_range($sformatf("vec%0d_latency", i), n, 11, 14);
      chk($sformatf("vec%0d_db", i), keys_db, tbl[i].db);
      chk($sformatf("vec%0d_press", i), press_pulse, tbl[i].pr);
      chk($sformatf("vec%0d_release", i), release_pulse, tbl[i].rl);
      chk($sformatf("vec%0d_any_key", i), any_key, |tbl[i].db);
      chk($sformatf("vec%0d_early_strobe", i), early, 0);
      step();
      chk($sformatf("vec%0d_strobes_clear", i), {press_pulse, release_pulse}, 24'h0);
    end

    // Reset mid-operation with key 0 held.
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("midrst_outputs", {keys_db, press_pulse, any_key}, 64'h0);
    chk("midrst_no_release", release_pulse, 12'h000);
    rst = 1'b0;
    n = 31;
    cnt_a = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (release_pulse != 12'h000) cnt_a++;
      if (press_pulse[0]) begin
        n = c;
        break;
      end
    end
    chk_range("midrst_repress_latency", n, 11, 14);
    chk("midrst_repress_db", keys_db, 12'h001);
    chk("midrst_release_count", cnt_a, 0);

    // Default parameters: first press, then reset and re-press.
    keys2 = 12'h001;
    step();
    rst2 = 1'b0;
    n = 2001;
    for (int c = 1; c <= 2000; c++) begin
      step();
      if (press2[0]) begin
        n = c;
        break;
      end
    end
    chk_range("default_press_latency", n, 1001, 1502);
    chk("default_press_db", keys_db2, 12'h001);
    repeat (3) step();
    rst2 = 1'b1;
    step();
    chk("default_midrst_outputs", {keys_db2, press2, release2, any_key2}, 64'h0);
    rst2 = 1'b0;
    n = 2001;
    cnt_a = 0;
    for (int c = 1; c <= 2000; c++) begin
      step();
      if (release2 != 12'h000) cnt_a++;
      if (press2[0]) begin
        n = c;
        break;
      end
    end
    chk_range("default_repress_latency", n, 1001, 1502);
    chk("default_release_count", cnt_a, 0);
    chk("default_any_key", any_key2, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Per-key synchroniser and debouncer for the 12 piano keys. It sits directly upstream of the key priority encoder in the piano top level. It takes the raw asynchronous key pins ({uio_in[3:0], ui_in}) and delivers clean, glitch-free key levels plus one-cycle press/release events. Downstream logic (priority encoder, future demo-mode interrupt) consumes only `keys_db`, never raw pins.

## Interface
- `NUM_KEYS`, default 12: number of independent key channels; must be ≥ 1.
- `TICK_DIV`, default 500: sample prescaler period in `clk` cycles; must be ≥ 2. The 10 MHz clock gives a 50 µs sample period.
- `CNT_MAX`, default 3: integrator saturation value, i.e. the number of consistent samples needed to change state; must be ≥ 1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `keys_raw`  in  NUM_KEYS  asynchronous raw key levels; 1 = pressed.
- `keys_db`  out  NUM_KEYS  debounced key levels; registered.
- `press_pulse`  out  NUM_KEYS  one-cycle strobe when `keys_db[i]` goes 0→1.
- `release_pulse`  out  NUM_KEYS  one-cycle strobe when `keys_db[i]` goes 1→0.
- `any_key`  out  1  OR of `keys_db`; registered, and updates on the same edge as `keys_db`.

## Operation
- **Synchroniser:** two-flop synchroniser per key (`sync1`, `sync2`). It is reset to 0.
- **Prescaler:** a counter of width $clog2(TICK_DIV).
  - Counts 0..TICK_DIV-1 and then wraps to 0.
  - `tick` is combinational and high in the cycle where the count equals TICK_DIV-1.
  - Exactly one `tick` occurs every TICK_DIV cycles.
- **Integrators:** one saturating integrator per key, of width $clog2(CNT_MAX+1). Updates happen only on `tick`:
  - if `sync2[i]`=1: `integ <= min(integ+1, CNT_MAX)`;
  - if `sync2[i]`=0: `integ <= max(integ-1, 0)`.
- **Output state per key (hysteresis):**
  - on a `tick` edge where the next integrator value equals CNT_MAX and `keys_db[i]`=0, set `keys_db[i]`=1;
  - on a `tick` edge where the next integrator value equals 0 and `keys_db[i]`=1, clear `keys_db[i]`=0;
  - otherwise hold `keys_db[i]`.
- **Event strobes:** `press_pulse[i]` / `release_pulse[i]` are registered and asserted on the same edge that `keys_db[i]` changes. They are high for exactly one cycle, since changes occur only on `tick` and TICK_DIV ≥ 2.
- **Channel independence:** all channels are independent. Any number of keys may change on the same `tick`. No priority or arbitration is applied here; that is the encoder's job.
- **Integrator bounds:** integrator values never exceed CNT_MAX and never underflow below 0. Saturation is the only wrap protection, and no integrator ever wraps.

## Timing
- **Reset:** on a `rst` edge, `sync1`, `sync2`, prescaler, all integrators, `keys_db`, `press_pulse`, `release_pulse` and `any_key` are all set to 0.
  - The first `tick` occurs in cycle TICK_DIV-1 after the edge where `rst` is sampled low.
- **Reset mid-operation:** asserting `rst` while keys are held clears all state on the next edge.
  - Keys still held after release of reset re-debounce from 0. This produces a fresh `press_pulse` after the normal latency.
  - No `release_pulse` is generated by reset itself.
- **Press latency:** the raw level must be stable. The latency from the first edge where it is sampled to the `keys_db` rise is between 2+(CNT_MAX-1)·TICK_DIV+1 and 2+CNT_MAX·TICK_DIV cycles. Release latency is the same.
- **Glitch rejection:**
  - A raw pulse shorter than TICK_DIV cycles can move an integrator by at most 1.
  - With CNT_MAX ≥ 2 and `keys_db` settled, such a pulse never toggles the output.
- **Throughput:** there is no handshake. Outputs are valid every cycle, and downstream samples `keys_db` combinationally into its own register.

## Test plan
Benches run with TICK_DIV=4, CNT_MAX=3 unless stated.

- **Reset values:** assert `rst` 3 cycles with `keys_raw`=12'hFFF → all outputs 0 during and 1 cycle after reset.
- **Single key press and release:** release reset with keys=0, then set `keys_raw[0]`=1 and hold.
  - `keys_db[0]` rises 11–14 cycles later; `press_pulse[0]` is high exactly that one cycle; `any_key`=1.
  - Clear the bit → `keys_db[0]` falls 11–14 cycles later with a single `release_pulse[0]`.
- **Glitch rejection:** with `keys_db[5]`=0, pulse `keys_raw[5]` high for 3 cycles every 12 cycles, 10 times → `keys_db[5]` stays 0 and `press_pulse` stays 0.
- **Chatter then settle:** toggle `keys_raw[11]` every 5 cycles for 40 cycles, then hold 1.
  - Exactly one `press_pulse[11]`, and none while chattering.
  - `keys_db[11]`=1 within 14 cycles of the final settle.
- **Simultaneous events:** `keys_raw` 12'h000→12'hA5A on one edge → `keys_db`=12'hA5A on a single edge and `press_pulse`=12'hA5A for one cycle.
  - Then change to 12'h5A5 → the same edge shows `keys_db`=12'h5A5, `press_pulse`=12'h5A5 and `release_pulse`=12'hA5A.
- **Reset mid-operation:** with `keys_db`=12'h001 held, assert `rst` 1 cycle → outputs 0, no `release_pulse`.
  - `press_pulse[0]` re-fires 11–14 cycles after reset release.
  - Repeat with default parameters to check a 1001–1502-cycle latency.
